frame_uart_sender: RTL and testbench



---
 rtl/image_pkg.sv | 25 ++
 rtl/uart_tx_byte.sv | 79 +++++++
 rtl/frame_uart_sender.sv | 114 +++++++++++
 tb/tb_frame_uart_sender.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and constants for the frame sender: pixel format, frame sync bytes
// and the sender FSM state encoding.
package image_pkg;

  typedef logic [11:0] pixel_t;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_FETCH,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } fs_state_t;

  // The top nibble stays zero so a high byte can never alias HDR0.
  function automatic logic [7:0] hi_byte(input pixel_t p);
    return {4'h0, p[11:8]};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. tx_busy drops during the last stop-bit cycle so a
// new byte can be queued back to back with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     BIT_STOP = 4'd9;

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last    = busy_q && (bit_q == BIT_STOP) && (cnt_q == CNT_LAST);
  assign tx_done = last;
  assign tx_busy = busy_q && !last;
  assign tx      = tx_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    busy_d  = busy_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (tx_start && !tx_busy) begin
      busy_d  = 1'b1;
      tx_d    = 1'b0;
      shift_d = tx_data;
      bit_d   = 4'd0;
      cnt_d   = '0;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (bit_q == BIT_STOP) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          // Shifting ones in from the top makes the ninth slot the stop bit.
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (reset) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_uart_sender.sv
// Streams one frame out of the frame buffer over UART: two sync bytes, then each
// pixel as high nibble byte and low byte, then raises image_ready until reset.
module frame_uart_sender
  import image_pkg::*;
#(
  parameter  int IMG_WIDTH    = 320,
  parameter  int IMG_HEIGHT   = 240,
  parameter  int CLKS_PER_BIT = 434,
  parameter  int READ_LATENCY = 2,
  localparam int N            = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW           = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  pixel_t        pixel_in,
  output logic [AW-1:0] pixel_addr,
  output logic          uart_tx,
  output logic          busy,
  output logic          image_ready
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
  localparam logic [2:0]    LAT_LAST  = 3'(READ_LATENCY);

  fs_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    lat_q, lat_d;
  logic [7:0]    pix_lo_q, pix_lo_d;
  logic          tx_start, tx_busy, tx_done;
  logic [7:0]    tx_data;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (uart_tx)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    pix_lo_d = pix_lo_q;
    tx_start = 1'b0;
    tx_data  = HDR0;
    unique case (state_q)
      S_IDLE: begin
        tx_start = 1'b1;
        state_d  = S_HDR0;
      end
      S_HDR0: if (tx_done) begin
        tx_start = 1'b1;
        tx_data  = HDR1;
        state_d  = S_HDR1;
      end
      S_HDR1: if (tx_done) begin
        lat_d   = '0;
        state_d = S_FETCH;
      end
      // The high byte goes out straight from pixel_in so the inter-byte gap
      // is only the read latency.
      S_FETCH: begin
        if (lat_q == LAT_LAST && !tx_busy) begin
          pix_lo_d = pixel_in[7:0];
          tx_start = 1'b1;
          tx_data  = hi_byte(pixel_in);
          state_d  = S_SEND_HI;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_SEND_HI: if (tx_done) begin
        tx_start = 1'b1;
        tx_data  = pix_lo_q;
        state_d  = S_SEND_LO;
      end
      S_SEND_LO: if (tx_done) begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          lat_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lat_q    <= '0;
      pix_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      pix_lo_q <= pix_lo_d;
    end
  end

  assign pixel_addr  = addr_q;
  assign image_ready = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_frame_uart_sender.sv
// Self-checking bench: a line decoder feeds a byte scoreboard, and a table of
// frame scenarios plus hand-written reset sequences drives the sender.
module tb_frame_uart_sender;
  import image_pkg::*;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int NP  = W * H;
  localparam int NB  = 2 + 2 * NP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  pixel_t     pixel_in;
  logic [2:0] pixel_addr;
  logic       uart_tx, busy, image_ready;

  frame_uart_sender #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .CLKS_PER_BIT(CPB), .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .pixel_addr (pixel_addr),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .image_ready(image_ready)
  );

  always #5 clk = ~clk;

  // Frame buffer model with a two-cycle read pipeline.
  pixel_t     mem [NP];
  logic [2:0] a1, a2;
  always @(posedge clk) begin
    a1 <= pixel_addr;
    a2 <= a1;
  end
  assign pixel_in = mem[a2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] exp_q[$];

  // Line decoder: samples every cycle, requires each bit to hold for CPB samples.
  logic       dec_active = 1'b0;
  int         smp;
  logic       cur;
  logic       width_bad;
  logic [7:0] rx_data;
  int         rx_count = 0;
  int         last_stop_cyc;
  logic       gap_valid = 1'b0;
  logic       ir_pending = 1'b0;
  logic       first_of_frame = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      dec_active     = 1'b0;
      gap_valid      = 1'b0;
      ir_pending     = 1'b0;
      first_of_frame = 1'b1;
    end else begin
      if (ir_pending) begin
        check("image_ready_rise", image_ready, 1);
        ir_pending = 1'b0;
      end
      if (!dec_active) begin
        if (uart_tx == 1'b0) begin
          dec_active = 1'b1;
          smp        = 1;
          cur        = 1'b0;
          width_bad  = 1'b0;
          rx_data    = '0;
          if (gap_valid) check("byte_gap_le3", (cyc - last_stop_cyc - 1) <= 3, 1);
          if (first_of_frame) check("busy_at_first_start", busy, 1);
          first_of_frame = 1'b0;
        end
      end else begin
        if (smp % CPB == 0) begin
          cur = uart_tx;
          if (smp / CPB >= 1 && smp / CPB <= 8) rx_data[smp/CPB-1] = uart_tx;
        end else if (uart_tx !== cur) begin
          width_bad = 1'b1;
        end
        smp++;
        if (smp == 10 * CPB) begin
          dec_active = 1'b0;
          rx_count++;
          check("stop_bit", cur, 1);
          check("bit_width", width_bad, 0);
          check("rx_byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", rx_data, exp_q.pop_front());
          check("image_ready_low_in_frame", image_ready, 0);
          if (exp_q.size() == 0) ir_pending = 1'b1;
          last_stop_cyc = cyc;
          gap_valid     = 1'b1;
        end
      end
    end
  end

  typedef struct {
    int     rst_cycles;
    int     ovr_addr;
    pixel_t ovr_val;
    int     exp_nbytes;
    int     exp_last_addr;
  } vec_t;

  vec_t vecs [3];

  task automatic load_mem(input int ovr_addr, input pixel_t ovr_val);
    for (int a = 0; a < NP; a++) mem[a] = 12'hA00 + 12'(a);
    if (ovr_addr >= 0) mem[ovr_addr] = ovr_val;
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int a = 0; a < NP; a++) begin
      exp_q.push_back({4'h0, mem[a][11:8]});
      exp_q.push_back(mem[a][7:0]);
    end
  endtask

  task automatic assert_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_and_wait(input int exp_nbytes, input int exp_last_addr);
    int base;
    base = rx_count;
    push_frame();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4000 && !image_ready; k++) @(negedge clk);
    check("frame_done", image_ready, 1);
    check("frame_byte_count", rx_count - base, exp_nbytes);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_pixel_addr", pixel_addr, exp_last_addr);
    check("done_busy", busy, 0);
    check("done_uart_tx", uart_tx, 1);
  endtask

  initial begin
    int   base;
    logic hold_bad;

    vecs[0] = '{rst_cycles: 10, ovr_addr: -1, ovr_val: 12'h000, exp_nbytes: NB, exp_last_addr: NP - 1};
    vecs[1] = '{rst_cycles: 3,  ovr_addr: 3,  ovr_val: 12'hFFF, exp_nbytes: NB, exp_last_addr: NP - 1};
    vecs[2] = '{rst_cycles: 1,  ovr_addr: 5,  ovr_val: 12'h0A5, exp_nbytes: NB, exp_last_addr: NP - 1};

    load_mem(-1, 12'h000);
    repeat (5) @(negedge clk);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_image_ready", image_ready, 0);
    check("reset_pixel_addr", pixel_addr, 0);

    for (int i = 0; i < 3; i++) begin
      assert_reset(vecs[i].rst_cycles);
      load_mem(vecs[i].ovr_addr, vecs[i].ovr_val);
      check("between_frames_image_ready", image_ready, 0);
      check("between_frames_pixel_addr", pixel_addr, 0);
      check("between_frames_uart_tx", uart_tx, 1);
      release_and_wait(vecs[i].exp_nbytes, vecs[i].exp_last_addr);

      if (i == 0) begin
        base     = rx_count;
        hold_bad = 1'b0;
        repeat (1000) begin
          @(negedge clk);
          if (uart_tx !== 1'b1 || image_ready !== 1'b1 || pixel_addr !== 3'd7 || busy !== 1'b0)
            hold_bad = 1'b1;
        end
        check("hold_no_extra_bytes", rx_count - base, 0);
        check("hold_outputs_stable", hold_bad, 0);
      end
    end

    // Abort in the middle of the third data byte, then expect a clean restart.
    assert_reset(2);
    load_mem(-1, 12'h000);
    base = rx_count;
    push_frame();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2000 && rx_count < base + 4; k++) @(negedge clk);
    check("abort_reached_byte4", rx_count - base, 4);
    for (int k = 0; k < 100 && !dec_active; k++) @(negedge clk);
    check("abort_in_byte5", dec_active, 1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("abort_uart_tx", uart_tx, 1);
    check("abort_image_ready", image_ready, 0);
    check("abort_pixel_addr", pixel_addr, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    release_and_wait(NB, NP - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
